// File: rtl/addr_gen_ind.sv
// Program counter update unit plus indirect-pointer resolver for a 65xx-style core.
// Walks a 2- or 3-byte pointer in bank 0, then forms the indexed effective address.
module addr_gen_ind #(
    parameter int PCW = 16,
    parameter int BW  = 8,
    parameter int IW  = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic [2:0]      LOAD_PC,
    input  logic            GOT_INT,
    input  logic [7:0]      D_IN,
    input  logic [7:0]      DR,
    input  logic [IW-1:0]   X,
    input  logic [IW-1:0]   Y,
    input  logic [15:0]     D,
    input  logic [BW-1:0]   DBR,
    input  logic            E6502,
    input  logic            PTR_START,
    input  logic [1:0]      PTR_IDX,
    input  logic            PTR_LONG,
    input  logic            MEM_ACK,
    output logic            MEM_REQ,
    output logic [15:0]     MEM_ADDR,
    output logic [PCW-1:0]  PC,
    output logic [BW+15:0]  EA,
    output logic            EA_VALID,
    output logic            BUSY,
    output logic            PAGE_CROSS,
    output logic            JUMP_NOFL
);

    localparam int EAW = BW + 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        FETCH_BK,
        INDEX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [15:0]     ptr_q, ptr_d;
    logic            page_q, page_d;
    logic            long_q, long_d;
    logic [1:0]      idx_sel_q, idx_sel_d;
    logic [7:0]      lo_q, lo_d;
    logic [7:0]      hi_q, hi_d;
    logic [BW-1:0]   bank_q, bank_d;
    logic [EAW-1:0]  ea_q, ea_d;
    logic            cross_q, cross_d;

    logic [PCW-1:0]  pc_rel8;
    logic [IW-1:0]   idx_raw;
    logic [EAW-1:0]  idx_ext;
    logic [8:0]      lo_sum;
    logic [15:0]     fetch_off;

    assign pc_rel8   = pc_q + {{(PCW-8){DR[7]}}, DR};
    assign JUMP_NOFL = (LOAD_PC == 3'b100) && (pc_q[8] == pc_rel8[8]);

    always_comb begin
        pc_d = pc_q;
        if (EN) begin
            case (LOAD_PC)
                3'b001:         if (!GOT_INT) pc_d = pc_q + PCW'(1);
                3'b010:         pc_d = PCW'({D_IN, DR});
                3'b011, 3'b101: pc_d = pc_q + PCW'({D_IN, DR});
                3'b100:         pc_d = pc_rel8;
                3'b110:         pc_d = PCW'(ea_q[15:0]);
                3'b111:         pc_d = pc_q - PCW'(3);
                default:        pc_d = pc_q;
            endcase
        end
    end

    // In emulation mode only the low index byte takes part in the sum.
    always_comb begin
        case (idx_sel_q)
            2'b01:   idx_raw = X;
            2'b10:   idx_raw = Y;
            default: idx_raw = '0;
        endcase
        idx_ext = E6502 ? EAW'(idx_raw[7:0]) : EAW'(idx_raw);
        lo_sum  = {1'b0, lo_q} + {1'b0, idx_raw[7:0]};
    end

    always_comb begin
        case (state_q)
            FETCH_HI: fetch_off = 16'd1;
            FETCH_BK: fetch_off = 16'd2;
            default:  fetch_off = 16'd0;
        endcase
    end

    // Direct page at a page boundary in emulation mode wraps within the page.
    assign MEM_ADDR = page_q ? {ptr_q[15:8], ptr_q[7:0] + fetch_off[7:0]}
                             : ptr_q + fetch_off;
    assign MEM_REQ  = (state_q == FETCH_LO) || (state_q == FETCH_HI) || (state_q == FETCH_BK);
    assign EA_VALID = (state_q == DONE);
    assign BUSY     = (state_q != IDLE);
    assign PC         = pc_q;
    assign EA         = ea_q;
    assign PAGE_CROSS = cross_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        page_d    = page_q;
        long_d    = long_q;
        idx_sel_d = idx_sel_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        bank_d    = bank_q;
        ea_d      = ea_q;
        cross_d   = cross_q;
        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (PTR_START) begin
                        page_d    = E6502 && (D[7:0] == 8'h00);
                        ptr_d     = (E6502 && (D[7:0] == 8'h00)) ? {D[15:8], D_IN}
                                                                 : D + {8'h00, D_IN};
                        long_d    = PTR_LONG;
                        idx_sel_d = PTR_IDX;
                        state_d   = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (MEM_ACK) begin
                        lo_d    = D_IN;
                        state_d = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (MEM_ACK) begin
                        hi_d = D_IN;
                        if (long_q) begin
                            state_d = FETCH_BK;
                        end else begin
                            bank_d  = DBR;
                            state_d = INDEX;
                        end
                    end
                end
                FETCH_BK: begin
                    if (MEM_ACK) begin
                        bank_d  = D_IN[BW-1:0];
                        state_d = INDEX;
                    end
                end
                INDEX: begin
                    ea_d    = {bank_q, hi_q, lo_q} + idx_ext;
                    cross_d = lo_sum[8];
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ptr_q     <= '0;
            page_q    <= 1'b0;
            long_q    <= 1'b0;
            idx_sel_q <= 2'b00;
            lo_q      <= '0;
            hi_q      <= '0;
            bank_q    <= '0;
            ea_q      <= '0;
            cross_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ptr_q     <= ptr_d;
            page_q    <= page_d;
            long_q    <= long_d;
            idx_sel_q <= idx_sel_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            bank_q    <= bank_d;
            ea_q      <= ea_d;
            cross_q   <= cross_d;
        end
    end

endmodule

// File: tb/tb_addr_gen_ind.sv
// Directed bench for addr_gen_ind: PC modes, pointer walks, wait states, enable gaps and reset.
// A PC model and a per-operation EA model are checked alongside hand-computed literals.
module tb_addr_gen_ind;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic [2:0]  LOAD_PC;
    logic        GOT_INT;
    logic [7:0]  D_IN;
    logic [7:0]  DR;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] D;
    logic [7:0]  DBR;
    logic        E6502;
    logic        PTR_START;
    logic [1:0]  PTR_IDX;
    logic        PTR_LONG;
    logic        MEM_ACK;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic [15:0] PC;
    logic [23:0] EA;
    logic        EA_VALID;
    logic        BUSY;
    logic        PAGE_CROSS;
    logic        JUMP_NOFL;

    int          passCount = 0;
    int          checkCount = 0;
    logic        checking = 1'b0;
    logic        op_active = 1'b1;
    logic [15:0] exp_pc;
    logic [23:0] exp_ea = 24'h0;
    logic        exp_cross = 1'b0;

    addr_gen_ind #(.PCW(16), .BW(8), .IW(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .LOAD_PC(LOAD_PC), .GOT_INT(GOT_INT),
        .D_IN(D_IN), .DR(DR), .X(X), .Y(Y), .D(D), .DBR(DBR), .E6502(E6502),
        .PTR_START(PTR_START), .PTR_IDX(PTR_IDX), .PTR_LONG(PTR_LONG), .MEM_ACK(MEM_ACK),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .PC(PC), .EA(EA), .EA_VALID(EA_VALID),
        .BUSY(BUSY), .PAGE_CROSS(PAGE_CROSS), .JUMP_NOFL(JUMP_NOFL)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic stepClock();
        @(posedge CLK);
        #1;
    endtask

    // PC reference: the mode table applied with plain integer arithmetic, truncated to 16 bits.
    always @(posedge CLK or negedge RST_N) begin : pc_model
        int t;
        int off;
        if (!RST_N) begin
            exp_pc <= 16'h0;
        end else if (EN) begin
            off = DR[7] ? int'(DR) - 256 : int'(DR);
            case (LOAD_PC)
                3'b001:         t = GOT_INT ? int'(exp_pc) : int'(exp_pc) + 1;
                3'b010:         t = int'(D_IN) * 256 + int'(DR);
                3'b011, 3'b101: t = int'(exp_pc) + int'(D_IN) * 256 + int'(DR);
                3'b100:         t = int'(exp_pc) + off;
                3'b110:         t = int'(exp_ea[15:0]);
                3'b111:         t = int'(exp_pc) - 3;
                default:        t = int'(exp_pc);
            endcase
            exp_pc <= t[15:0];
        end
    end

    always @(negedge CLK) begin : compare
        int   s;
        logic exp_nofl;
        if (checking) begin
            s = int'(exp_pc) + (DR[7] ? int'(DR) - 256 : int'(DR));
            exp_nofl = (LOAD_PC == 3'b100) && (exp_pc[8] == s[8]);
            checkOutput("pc_model", PC, exp_pc);
            checkOutput("jump_nofl_model", JUMP_NOFL, exp_nofl);
            if (!op_active) begin
                checkOutput("idle_ea", EA, exp_ea);
                checkOutput("idle_page_cross", PAGE_CROSS, exp_cross);
                checkOutput("idle_busy", BUSY, 0);
                checkOutput("idle_ea_valid", EA_VALID, 0);
                checkOutput("idle_mem_req", MEM_REQ, 0);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] mode, input logic gi, input logic [7:0] din,
                                 input logic [7:0] drv, input logic [15:0] expPc, input logic expNofl);
        LOAD_PC = mode;
        GOT_INT = gi;
        D_IN    = din;
        DR      = drv;
        #1;
        checkOutput("jump_nofl_vec", JUMP_NOFL, expNofl);
        stepClock();
        LOAD_PC = 3'b000;
        GOT_INT = 1'b0;
        checkOutput("pc_vec", PC, expPc);
    endtask

    task automatic runPointer(input string name, input logic [15:0] dv, input logic [7:0] operand,
                              input logic [1:0] idx, input logic lng, input logic e65,
                              input logic [15:0] xv, input logic [15:0] yv, input logic [7:0] bank,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int hiWait, input int enGap, input logic busyStart,
                              input logic resetInHi, input logic [15:0] litAddr0,
                              input logic [15:0] litAddr1, input logic [23:0] litEa,
                              input logic litCross, input int litLat);
        logic        page;
        logic [15:0] ptr;
        logic [15:0] addrs [3];
        logic [7:0]  bytes [3];
        logic [23:0] idxv;
        logic [23:0] mdlEa;
        logic        mdlCross;
        int          mdlLat;
        int          nbytes;
        int          lat;
        int          guard;

        page = e65 && (dv[7:0] == 8'h00);
        ptr  = page ? {dv[15:8], operand} : dv + 16'(operand);
        for (int k = 0; k < 3; k++)
            addrs[k] = page ? {ptr[15:8], 8'(ptr[7:0] + k)} : 16'(ptr + k);
        bytes  = '{b0, b1, b2};
        nbytes = lng ? 3 : 2;
        idxv   = (idx == 2'b01) ? 24'(xv) : (idx == 2'b10) ? 24'(yv) : 24'h0;
        if (e65) idxv = idxv & 24'h0000FF;
        mdlEa    = {(lng ? b2 : bank), b1, b0} + idxv;
        mdlCross = (int'(b0) + int'(idxv[7:0])) > 255;
        mdlLat   = (lng ? 4 : 3) + hiWait + enGap;

        D = dv; X = xv; Y = yv; DBR = bank; E6502 = e65;
        PTR_IDX = idx; PTR_LONG = lng; D_IN = operand; PTR_START = 1'b1;
        op_active = 1'b1;
        stepClock();
        PTR_START = 1'b0;
        PTR_LONG  = ~lng;
        PTR_IDX   = ~idx;
        D         = 16'hFFFF;
        lat = 0;

        for (int k = 0; k < nbytes; k++) begin
            if (k == 1) begin
                for (int g = 0; g < enGap; g++) begin
                    EN = 1'b0; MEM_ACK = 1'b1; D_IN = 8'hAA;
                    stepClock();
                    lat++;
                    checkOutput({name, "_frozen_addr"}, MEM_ADDR, addrs[1]);
                    checkOutput({name, "_frozen_valid"}, EA_VALID, 0);
                end
                EN = 1'b1; MEM_ACK = 1'b0;
                if (resetInHi) begin
                    exp_ea = 24'h0; exp_cross = 1'b0; op_active = 1'b0;
                    RST_N = 1'b0;
                    #1;
                    checkOutput({name, "_rst_pc"}, PC, 0);
                    checkOutput({name, "_rst_ea"}, EA, 0);
                    checkOutput({name, "_rst_busy"}, BUSY, 0);
                    checkOutput({name, "_rst_req"}, MEM_REQ, 0);
                    checkOutput({name, "_rst_valid"}, EA_VALID, 0);
                    checkOutput({name, "_rst_cross"}, PAGE_CROSS, 0);
                    stepClock();
                    RST_N = 1'b1;
                    for (int i = 0; i < 4; i++) stepClock();
                    return;
                end
                for (int w = 0; w < hiWait; w++) begin
                    if (busyStart && w == 0) begin
                        PTR_START = 1'b1; D_IN = 8'h55;
                    end
                    checkOutput({name, "_wait_req"}, MEM_REQ, 1);
                    checkOutput({name, "_wait_addr"}, MEM_ADDR, addrs[1]);
                    stepClock();
                    lat++;
                    PTR_START = 1'b0;
                end
            end
            checkOutput({name, "_req"}, MEM_REQ, 1);
            checkOutput({name, "_addr_model"}, MEM_ADDR, addrs[k]);
            if (k == 0) checkOutput({name, "_addr0_lit"}, MEM_ADDR, litAddr0);
            if (k == 1) checkOutput({name, "_addr1_lit"}, MEM_ADDR, litAddr1);
            D_IN = bytes[k]; MEM_ACK = 1'b1;
            stepClock();
            lat++;
            MEM_ACK = 1'b0; D_IN = 8'h00;
        end

        guard = 0;
        while (!EA_VALID && guard < 20) begin
            stepClock();
            lat++;
            guard++;
        end
        checkOutput({name, "_valid_seen"}, EA_VALID, 1);
        checkOutput({name, "_latency_lit"}, lat, litLat);
        checkOutput({name, "_latency_model"}, lat, mdlLat);
        checkOutput({name, "_ea_lit"}, EA, litEa);
        checkOutput({name, "_ea_model"}, EA, mdlEa);
        checkOutput({name, "_cross_lit"}, PAGE_CROSS, litCross);
        checkOutput({name, "_cross_model"}, PAGE_CROSS, mdlCross);
        checkOutput({name, "_busy_done"}, BUSY, 1);
        exp_ea = mdlEa;
        exp_cross = mdlCross;
        stepClock();
        op_active = 1'b0;
        checkOutput({name, "_valid_pulse"}, EA_VALID, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST_N = 1'b0; EN = 1'b0; LOAD_PC = 3'b000; GOT_INT = 1'b0; D_IN = 8'h00; DR = 8'h00;
        X = 16'h0; Y = 16'h0; D = 16'h0; DBR = 8'h0; E6502 = 1'b0;
        PTR_START = 1'b0; PTR_IDX = 2'b00; PTR_LONG = 1'b0; MEM_ACK = 1'b0;
        #12;
        checkOutput("reset_pc", PC, 0);
        checkOutput("reset_ea", EA, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_req", MEM_REQ, 0);
        checkOutput("reset_valid", EA_VALID, 0);
        checkOutput("reset_cross", PAGE_CROSS, 0);
        stepClock();
        RST_N = 1'b1; EN = 1'b1;
        checking = 1'b1; op_active = 1'b0;

        applyStimulus(3'b010, 1'b0, 8'h10, 8'hF0, 16'h10F0, 1'b0);
        applyStimulus(3'b100, 1'b0, 8'h00, 8'h20, 16'h1110, 1'b0);
        applyStimulus(3'b001, 1'b1, 8'h00, 8'h00, 16'h1110, 1'b0);
        applyStimulus(3'b001, 1'b0, 8'h00, 8'h00, 16'h1111, 1'b0);
        applyStimulus(3'b010, 1'b0, 8'h00, 8'h02, 16'h0002, 1'b0);
        applyStimulus(3'b111, 1'b0, 8'h00, 8'h00, 16'hFFFF, 1'b0);
        applyStimulus(3'b100, 1'b0, 8'h00, 8'hFE, 16'hFFFD, 1'b1);
        applyStimulus(3'b011, 1'b0, 8'h00, 8'h05, 16'h0002, 1'b0);
        applyStimulus(3'b101, 1'b0, 8'h12, 8'h34, 16'h1236, 1'b0);
        applyStimulus(3'b000, 1'b0, 8'h00, 8'h00, 16'h1236, 1'b0);
        EN = 1'b0;
        applyStimulus(3'b001, 1'b0, 8'h00, 8'h00, 16'h1236, 1'b0);
        EN = 1'b1;

        runPointer("short_y", 16'h0010, 8'h20, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0005, 8'h7E,
                   8'h34, 8'h12, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0030, 16'h0031, 24'h7E1239, 1'b0, 3);
        applyStimulus(3'b110, 1'b0, 8'h00, 8'h00, 16'h1239, 1'b0);

        LOAD_PC = 3'b001;
        runPointer("long_x", 16'h0000, 8'h40, 2'b01, 1'b1, 1'b0, 16'h0001, 16'h0000, 8'h7E,
                   8'hFF, 8'hFF, 8'h01, 0, 0, 1'b0, 1'b0, 16'h0040, 16'h0041, 24'h020000, 1'b1, 4);
        LOAD_PC = 3'b000;
        checkOutput("pc_concurrent", PC, 16'h123F);

        runPointer("emu_wrap", 16'h0000, 8'hFF, 2'b01, 1'b0, 1'b1, 16'h0180, 16'h0000, 8'h00,
                   8'h90, 8'h20, 8'h00, 0, 0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 24'h002110, 1'b1, 3);

        runPointer("wait_busy", 16'h1200, 8'h34, 2'b00, 1'b0, 1'b0, 16'h0010, 16'h0020, 8'h01,
                   8'hCD, 8'hAB, 8'h00, 3, 0, 1'b1, 1'b0, 16'h1234, 16'h1235, 24'h01ABCD, 1'b0, 6);

        runPointer("en_gap", 16'hFFFF, 8'h00, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h00FF, 8'h10,
                   8'h01, 8'h02, 8'h00, 0, 2, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 24'h100300, 1'b1, 5);

        runPointer("reset_mid", 16'h0010, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00,
                   8'h11, 8'h22, 8'h00, 0, 0, 1'b0, 1'b1, 16'h0010, 16'h0011, 24'h0, 1'b0, 0);

        runPointer("emu_nopage", 16'h0001, 8'hFF, 2'b01, 1'b0, 1'b1, 16'h0105, 16'h0000, 8'h00,
                   8'hFE, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0101, 24'h000103, 1'b1, 3);

        for (int i = 0; i < 3; i++) stepClock();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/addr_gen_ind.md
ADDR_GEN_IND -- requirements
Module: addr_gen_ind

Interface
REQ-001 SHALL have parameter PCW, default 16, program-counter width (16..24).
REQ-002 SHALL have parameter BW, default 8, bank width of the effective address.
REQ-003 SHALL have parameter IW, default 16, index-register width (8 or 16).
REQ-004 SHALL have port CLK  in  1  clock, all state updates on the rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN  in  1  clock enable; when 0, all registers and the FSM hold.
REQ-007 SHALL have port LOAD_PC  in  3  PC update mode.
REQ-008 SHALL have port GOT_INT  in  1  interrupt taken; suppresses the PC increment.
REQ-009 SHALL have port D_IN  in  8  data bus byte.
REQ-010 SHALL have port DR  in  8  latched operand byte.
REQ-011 SHALL have ports X and Y  in  IW  index registers.
REQ-012 SHALL have port D  in  16  direct-page base.
REQ-013 SHALL have port DBR  in  BW  data bank.
REQ-014 SHALL have port E6502  in  1  emulation mode.
REQ-015 SHALL have port PTR_START  in  1  start indirect-pointer resolution; the operand is on D_IN.
REQ-016 SHALL have port PTR_IDX  in  2  post-index select: 00 none, 01 X, 10 Y, 11 none.
REQ-017 SHALL have port PTR_LONG  in  1  3-byte pointer that includes a bank byte.
REQ-018 SHALL have port MEM_ACK  in  1  memory returned D_IN for the current request.
REQ-019 SHALL have port MEM_REQ  out  1  pointer-byte read request.
REQ-020 SHALL have port MEM_ADDR  out  16  pointer-byte address; the bank is always 0.
REQ-021 SHALL have ports PC  out  PCW;  EA  out  BW+16;  EA_VALID  out  1;  BUSY  out  1;  PAGE_CROSS  out  1;  JUMP_NOFL  out  1.

Function
REQ-022 PC SHALL update only when EN=1, according to LOAD_PC:
- 000: hold.
- 001: PC+1, or hold if GOT_INT=1.
- 010: {D_IN,DR} zero-extended.
- 011 and 101: PC + {D_IN,DR}.
- 100: PC + sign-extended DR.
- 110: EA[15:0].
- 111: PC-3.
All results SHALL wrap modulo 2^PCW.
REQ-023 JUMP_NOFL SHALL be combinational and equal 1 iff LOAD_PC=100 and bit 8 of PC equals bit 8 of PC+sext(DR).
REQ-024 The FSM SHALL have the states IDLE, FETCH_LO, FETCH_HI, FETCH_BK, INDEX and DONE.
REQ-025 In IDLE, EN & PTR_START SHALL latch PTR = D + D_IN (16-bit, wrapping) and go to FETCH_LO. If E6502=1 and D[7:0]=0, PTR SHALL instead be {D[15:8],D_IN}.
REQ-026 In each FETCH state, MEM_REQ SHALL be 1 and MEM_ADDR SHALL be PTR+k, with k = 0, 1, 2 for LO, HI, BK. The sum SHALL wrap at 16 bits; in the E6502 page case of REQ-025, only the low byte SHALL increment (page wrap).
REQ-027 In a FETCH state, EN & MEM_ACK SHALL latch D_IN into the matching pointer byte and advance:
- LO -> HI.
- HI -> BK if PTR_LONG=1, else -> INDEX with bank = DBR.
- BK -> INDEX.
Without MEM_ACK the state SHALL hold (wait states allowed).
REQ-028 PTR_LONG and PTR_IDX SHALL be sampled at PTR_START and held for the whole operation.
REQ-029 In INDEX, EA SHALL be registered as {bank,hi,lo} + zero-extended index. With E6502=1 only index bits [7:0] SHALL be used. The carry SHALL propagate into the bank, and the bank SHALL wrap modulo 2^BW.
REQ-030 PAGE_CROSS SHALL be registered in INDEX as the carry out of bit 7 of the low-byte addition. It SHALL be 0 when no index is selected.
REQ-031 DONE SHALL assert EA_VALID for exactly one EN cycle, then return to IDLE.
REQ-032 EA and PAGE_CROSS SHALL hold until the next INDEX.
REQ-033 BUSY SHALL be 1 in every state except IDLE.
REQ-034 PTR_START while BUSY=1 SHALL be ignored, and MEM_ACK outside the FETCH states SHALL be ignored.
REQ-035 With zero wait states and a start at edge N, EA_VALID SHALL be high in cycle N+4, or N+5 when PTR_LONG=1.
REQ-036 PC updates and FSM operation SHALL be independent and may occur in the same cycle.

Reset
REQ-037 RST_N=0 SHALL asynchronously clear PC, EA, the PTR and byte registers, MEM_REQ, EA_VALID, BUSY and PAGE_CROSS to 0, and force the FSM to IDLE.
REQ-038 Reset mid-operation SHALL abandon the fetch; no EA_VALID SHALL follow.

Verification
REQ-039 Short pointer, Y index:
- Stimulus: D=0x0010, D_IN=0x20, PTR_IDX=10, Y=0x0005, DBR=0x7E; memory acks 0x34 then 0x12 with no wait.
- Response: MEM_ADDR 0x0030 then 0x0031; EA=0x7E1239; PAGE_CROSS=0; EA_VALID in cycle N+4.
REQ-040 Long pointer with bank carry:
- Stimulus: PTR_LONG=1, bytes 0xFF,0xFF,0x01, X=0x0001.
- Response: EA=0x020000; PAGE_CROSS=1.
REQ-041 Emulation page wrap:
- Stimulus: E6502=1, D=0x0000, D_IN=0xFF.
- Response: MEM_ADDR 0x00FF then 0x0000; X=0x0180 adds only 0x80.
REQ-042 Wait states and busy start:
- Stimulus: MEM_ACK withheld 3 cycles in FETCH_HI; PTR_START pulsed while BUSY=1.
- Response: MEM_ADDR and MEM_REQ stable; the second start is ignored; a single EA_VALID pulse.
REQ-043 PC modes:
- Stimulus (a): PC=0x10F0, DR=0x20, LOAD_PC=100.
- Response (a): PC=0x1110, JUMP_NOFL=0.
- Stimulus (b): LOAD_PC=001 with GOT_INT=1.
- Response (b): PC held.
- Stimulus (c): LOAD_PC=111 at PC=0x0002.
- Response (c): PC=0xFFFF.
REQ-044 Reset and enable:
- Stimulus: RST_N low during FETCH_HI; separately, EN=0 for 2 cycles mid-operation.
- Response: outputs 0 and IDLE immediately after reset; with EN=0, all state is frozen and EA_VALID is delayed by 2 cycles.
